// File: rtl/aac_result_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aac_pkg
// Description : Shared constants, result record and saturation helpers for
//               the AAC result drain (reader side of the adder-accumulator).
// Revision    : 1.0 - initial release
// ============================================================================
package aac_pkg;

  // Accumulator width is fixed by the AAC datapath.
  localparam int ACC_W = 28;
  localparam int OUT_W = 16;

  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // One buffered row result.
  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } aac_res_t;

  // Largest w-bit signed value, expressed in the ACC_W+1 compare domain.
  function automatic logic signed [ACC_W:0] sat_hi(input int w);
    logic signed [ACC_W:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Smallest w-bit signed value, expressed in the ACC_W+1 compare domain.
  function automatic logic signed [ACC_W:0] sat_lo(input int w);
    logic signed [ACC_W:0] r;
    r = '1;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b0;
    return r;
  endfunction

  // Shifts beyond ACC_W-1 leave only sign bits, so clamp there.
  function automatic logic [4:0] clamp_shift(input logic [4:0] s);
    return (s > 5'd27) ? 5'd27 : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aac_result_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aac_res_fifo
// Description : DEPTH x W synchronous FIFO with full/empty/count. A push that
//               arrives while full is only taken when a pop happens in the
//               same cycle; otherwise it is ignored (caller flags the drop).
// Ports       : clk, reset_n        - clock, async active-low reset
//               push_i / wdata_i    - write request and data
//               pop_i               - read request (head advances)
//               rdata_o             - head entry
//               full_o/empty_o      - occupancy flags
//               count_o             - entries held
// Revision    : 1.0 - initial release
// ============================================================================
module aac_res_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot freed by a simultaneous pop takes the new entry.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer wrap is implicit: DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/aac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : aac_result_drain
// Description : Reader side of the AAC adder-accumulator. Samples the running
//               sum one cycle after the last beat of a row, rescales and
//               saturates it to OUT_W bits, buffers it and hands it downstream
//               over valid/ready.
// Config      : `AAC_DRAIN_ROUND_EN - round half up before the shift
//               (undefined: plain truncating arithmetic shift).
// Ports       : clk, reset_n             - clock, async active-low reset
//               beat_valid, beat_last    - beat stream into the AAC
//               acc_sum                  - AAC running sum (signed)
//               cfg_shift                - arithmetic right-shift amount
//               clr_ovf                  - clears sticky ovf
//               acc_ready                - room for another row result
//               res_valid/ready/data/sat - result handshake
//               ovf                      - sticky: a result was dropped
//               rows_done                - results pushed (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module aac_result_drain
  import aac_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    beat_valid,
  input  logic                    beat_last,
  input  logic [ACC_W-1:0]        acc_sum,
  input  logic [4:0]              cfg_shift,
  input  logic                    clr_ovf,
  output logic                    acc_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUT_W-1:0]        res_data,
  output logic                    res_sat,
  output logic                    ovf,
  output logic [15:0]             rows_done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic signed [ACC_W:0] HI = sat_hi(OUT_W);
  localparam logic signed [ACC_W:0] LO = sat_lo(OUT_W);

  logic        cap_pend_q;
  logic        ovf_q, ovf_d;
  logic [15:0] rows_q;

  logic [4:0]              sh;
  logic signed [ACC_W:0]   ext, v;
  logic [OUT_W-1:0]        data_w;
  logic                    sat_w;

  logic [OUT_W:0]  fifo_rdata;
  logic            fifo_full, fifo_empty, pop, push_ok, drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ;

  // ---- scaling and saturation (evaluated in the capture cycle) ----
  assign sh  = clamp_shift(cfg_shift);
  assign ext = {acc_sum[ACC_W-1], acc_sum};

`ifdef AAC_DRAIN_ROUND_EN
  logic signed [ACC_W:0] rnd;
  always_comb begin
    rnd = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
  end
  // One spare bit absorbs the rounding carry of the most positive sum.
  assign v = (ext + rnd) >>> sh;
`else
  assign v = ext >>> sh;
`endif

  always_comb begin
    data_w = v[OUT_W-1:0];
    sat_w  = 1'b0;
    if (v > HI) begin
      data_w = HI[OUT_W-1:0];
      sat_w  = 1'b1;
    end else if (v < LO) begin
      data_w = LO[OUT_W-1:0];
      sat_w  = 1'b1;
    end
  end

  // ---- FIFO control ----
  assign pop     = res_valid & res_ready;
  assign push_ok = cap_pend_q & (~fifo_full | pop);
  assign drop    = cap_pend_q & fifo_full & ~pop;

  aac_res_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cap_pend_q),
    .pop_i   (pop),
    .wdata_i ({sat_w, data_w}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A pending capture already owns a slot, so count it against the depth.
  assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, cap_pend_q};
  assign acc_ready = (occ < DEPTH_C);

  // Head is forced to zero when empty so outputs are defined out of reset.
  assign res_valid = ~fifo_empty;
  assign res_data  = fifo_empty ? '0 : fifo_rdata[OUT_W-1:0];
  assign res_sat   = ~fifo_empty & fifo_rdata[OUT_W];

  // A new drop wins over a simultaneous clear.
  assign ovf_d     = drop | (ovf_q & ~clr_ovf);
  assign ovf       = ovf_q;
  assign rows_done = rows_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      rows_q     <= '0;
    end else begin
      cap_pend_q <= beat_valid & beat_last;
      ovf_q      <= ovf_d;
      if (push_ok) rows_q <= rows_q + 16'd1;
    end
  end

endmodule
`default_nettype wire
